lcd_bus_driver: RTL
===================

# lcd_bus_driver

- Low-level HD44780-compatible character-LCD bus engine.
- Sits directly downstream of the scoreboard command sequencer: accepts one `{op, data}` command at a time over a start/rdy handshake and drives `LCD_RS`/`LCD_RW`/`LCD_EN`/`LCD_DATA` with the required setup, enable-pulse and execution-wait timing.
- Optionally runs the panel power-on initialisation sequence by itself after reset.

## Interface
- `POWERON_CYC`, default 750000: wait after reset release before the first bus cycle (15 ms at 50 MHz).
- `SETUP_CYC`, default 2: RS/DATA-valid cycles before `LCD_EN` rises; minimum 1.
- `EN_HIGH_CYC`, default 25: `LCD_EN` high width; minimum 1.
- `CMD_WAIT_CYC`, default 2500: execution wait after `LCD_EN` falls, normal commands.
- `CLEAR_WAIT_CYC`, default 100000: execution wait after a clear (instruction 0x01).
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  command request; sampled only on an edge where `rdy`=1.
- `op`  input  4  0 NOP, 1 write instruction, 2 write character, 3 clear display, 4 re-init, 5 set cursor; 6–15 NOP.
- `data`  input  8  instruction byte / character code / cursor (`data[4]` = line, `data[3:0]` = column).
- `LCD_RS`  output  1  0 = instruction, 1 = character.
- `LCD_RW`  output  1  tied 0 (write-only).
- `LCD_EN`  output  1  enable strobe.
- `LCD_DATA`  output  8  bus byte.
- `rdy`  output  1  1 = idle, next command accepted.

## Operation
- **States:** PWRON → INIT → IDLE; per bus cycle SETUP → EN_HI → WAIT → back to caller (INIT or IDLE).
- **Counter:** one 20-bit down-counter, reloaded at each state entry.
- **Accept:** `start`=1 ∧ `rdy`=1 on an edge, with `op` in {1,2,3,5}.
  - Latches `LCD_RS` and `LCD_DATA`; `rdy` goes 0 next cycle; enters SETUP.
- **Byte mapping:**
  - op 1: RS=0, byte=`data`.
  - op 2: RS=1, byte=`data`.
  - op 3: RS=0, byte=0x01, wait=`CLEAR_WAIT_CYC`.
  - op 5: RS=0, byte=0x80 | (`data[4]` ? 0x40 : 0x00) | `data[3:0]`.
- **NOP op** (0, 6–15) with `start`: no bus activity, `rdy` stays 1.
- **op 4:** enters INIT (sequence below); `rdy` stays 0 until the sequence completes.
- **INIT sequence** (all RS=0): 0x38, 0x38, 0x0C, 0x01, 0x06.
  - 0x01 waits `CLEAR_WAIT_CYC`; all others wait `CMD_WAIT_CYC`.
- **Output holding:** `LCD_RS`/`LCD_DATA` hold their values after the bus cycle until the next accepted command. `LCD_RW` is constantly 0.
- **`start` outside an accept edge:** ignored, never queued.

## Timing
- **Reset values:** `LCD_EN`=0, `LCD_RS`=0, `LCD_RW`=0, `LCD_DATA`=0x00, `rdy`=0; state PWRON (INIT absent: IDLE).
- **Bus cycle, accept edge k:**
  - `LCD_EN` rises at edge k+`SETUP_CYC` and falls at k+`SETUP_CYC`+`EN_HIGH_CYC`.
  - `rdy` returns to 1 at k+`SETUP_CYC`+`EN_HIGH_CYC`+wait.
- **Back-to-back:** a new command may be accepted on the same edge `rdy` rises; no bubble.
- **Reset mid-cycle:** `LCD_EN` drops to 0 asynchronously, the in-flight command is discarded, and the block restarts from PWRON.
- **Timing floor:** `LCD_DATA`/`LCD_RS` never change while `LCD_EN`=1, nor within `SETUP_CYC` before its rise.

## Configuration
- **`LCD_BUS_INIT_EN` defined:**
  - After reset: PWRON (`POWERON_CYC`), then the INIT sequence, then `rdy`=1.
  - op 4 re-runs INIT.
- **`LCD_BUS_INIT_EN` undefined:**
  - No PWRON/INIT states; `rdy`=1 on the first edge after `rst` deasserts.
  - op 4 is a NOP.
  - Upstream must issue initialisation itself.

## Test plan
Bench parameters: `POWERON_CYC`=20, `SETUP_CYC`=2, `EN_HIGH_CYC`=4, `CMD_WAIT_CYC`=10, `CLEAR_WAIT_CYC`=40.
- **Power-up (`LCD_BUS_INIT_EN`):** release `rst` → exactly 5 `LCD_EN` pulses, each 4 cycles wide, carrying 0x38, 0x38, 0x0C, 0x01, 0x06; `rdy` rises 130 cycles after release.
- **Character write:** op 2, data 0x35 → RS=1, DATA=0x35; EN high on cycles 2–5 after accept; `rdy` back at +16; DATA still 0x35 afterwards.
- **Clear and cursor:** op 3 → byte 0x01, `rdy` back at +46; then op 5, data 0x13 → byte 0xC3, RS=0.
- **Handshake edges:**
  - `start` held with `rdy`=0 → no second pulse.
  - op 9 with `start` → no EN pulse, `rdy` stays 1.
  - Two commands accepted on consecutive `rdy` edges → exactly two pulses.
- **Reset mid-cycle:** assert `rst` while EN=1 → EN=0 and `rdy`=0 immediately, DATA=0x00; release → full init sequence repeats.
- **Macro undefined:** `rdy`=1 one cycle after release; op 4 → no bus activity.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// HD44780-style character-LCD bus engine: one {op,data} command per start/rdy handshake.
// Define LCD_BUS_INIT_EN to run the power-on wait and panel init sequence after reset (op 4 re-runs it).
module lcd_bus_driver #(
  parameter int POWERON_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] data,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       rdy
);

  localparam logic [19:0] PWRON_LD = 20'(POWERON_CYC - 1);
  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] ENHI_LD  = 20'(EN_HIGH_CYC - 1);
  localparam logic [19:0] CMD_LD   = 20'(CMD_WAIT_CYC - 1);
  localparam logic [19:0] CLEAR_LD = 20'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRON,
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_WAIT
  } state_t;

`ifdef LCD_BUS_INIT_EN
  localparam state_t RESET_STATE = S_PWRON;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t      state_q;
  logic [19:0] cnt_q;
  logic        rs_q;
  logic [7:0]  data_q;
  logic        en_q;
  logic        rdy_q;
  logic        in_init_q;
  logic [2:0]  idx_q;

  logic        go_d;
  logic        reinit_d;
  logic        rs_d;
  logic [7:0]  byte_d;
  logic [19:0] wait_ld_d;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: init_byte = 8'h38;
      3'd2:       init_byte = 8'h0C;
      3'd3:       init_byte = 8'h01;
      default:    init_byte = 8'h06;
    endcase
  endfunction

  always_comb begin
    go_d     = 1'b0;
    reinit_d = 1'b0;
    rs_d     = 1'b0;
    byte_d   = data;
    case (op)
      4'd1: go_d = 1'b1;
      4'd2: begin go_d = 1'b1; rs_d = 1'b1; end
      4'd3: begin go_d = 1'b1; byte_d = 8'h01; end
      4'd5: begin go_d = 1'b1; byte_d = {1'b1, data[4], 2'b00, data[3:0]}; end
`ifdef LCD_BUS_INIT_EN
      4'd4: reinit_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // A clear instruction needs the long execution wait, whichever op produced it.
  assign wait_ld_d = (!rs_q && data_q == 8'h01) ? CLEAR_LD : CMD_LD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RESET_STATE;
      cnt_q     <= PWRON_LD;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      rdy_q     <= 1'b0;
      in_init_q <= 1'b0;
      idx_q     <= 3'd0;
    end else begin
      case (state_q)
        S_PWRON: begin
          if (cnt_q == 20'd0) begin
            in_init_q <= 1'b1;
            idx_q     <= 3'd0;
            rs_q      <= 1'b0;
            data_q    <= init_byte(3'd0);
            cnt_q     <= SETUP_LD;
            state_q   <= S_SETUP;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        S_IDLE: begin
          if (rdy_q && start && go_d) begin
            rs_q    <= rs_d;
            data_q  <= byte_d;
            rdy_q   <= 1'b0;
            cnt_q   <= SETUP_LD;
            state_q <= S_SETUP;
          end else if (rdy_q && start && reinit_d) begin
            in_init_q <= 1'b1;
            idx_q     <= 3'd0;
            rs_q      <= 1'b0;
            data_q    <= init_byte(3'd0);
            rdy_q     <= 1'b0;
            cnt_q     <= SETUP_LD;
            state_q   <= S_SETUP;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt_q == 20'd0) begin
            en_q    <= 1'b1;
            cnt_q   <= ENHI_LD;
            state_q <= S_EN_HI;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        S_EN_HI: begin
          if (cnt_q == 20'd0) begin
            en_q    <= 1'b0;
            cnt_q   <= wait_ld_d;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        S_WAIT: begin
          // Init steps chain straight into the next byte so the sequence has no idle gaps.
          if (cnt_q == 20'd0) begin
            if (in_init_q && idx_q != 3'd4) begin
              idx_q   <= idx_q + 3'd1;
              rs_q    <= 1'b0;
              data_q  <= init_byte(idx_q + 3'd1);
              cnt_q   <= SETUP_LD;
              state_q <= S_SETUP;
            end else begin
              in_init_q <= 1'b0;
              rdy_q     <= 1'b1;
              state_q   <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        default: state_q <= RESET_STATE;
      endcase
    end
  end

  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = en_q;
  assign LCD_DATA = data_q;
  assign rdy      = rdy_q;

endmodule
